seg7_scan_reader: RTL and testbench

//  Reads back a multiplexed, active-low 7-segment display by scanning its digit enables and

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_scan_reader_if.sv | 24 ++
 rtl/seg7_pattern_encoder.sv | 23 ++
 rtl/seg7_scan_reader.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan reader: segment width,
// the hex-to-segment pattern table and the scan FSM state encoding.
package seg7_pkg;

    localparam int SEG_W = 7;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F, same table the decoder drives
    localparam logic [SEG_W-1:0] SEG7_PATTERNS [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        SETTLE,
        SAMPLE,
        STORE,
        PRESENT
    } state_t;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Frame output handshake of the scan reader: packed frame value, per-digit
// error flags and a valid/ready pair. The reader is the master.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   frame_err;
    logic                    valid;
    logic                    ready;

    modport master (
        output value,
        output frame_err,
        output valid,
        input  ready
    );

    modport slave (
        input  value,
        input  frame_err,
        input  valid,
        output ready
    );
endinterface

// File: rtl/seg7_pattern_encoder.sv
// Combinational inverse of the hex-to-7seg decoder: finds the table index of
// a segment pattern. hit is low when the pattern matches no hex digit.
module seg7_pattern_encoder
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [3:0]       hex_o,
    output logic             hit_o
);

    // Linear search of the 16-entry table; entries are unique so at most one hits
    always_comb begin
        hex_o = 4'h0;
        hit_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG7_PATTERNS[i]) begin
                hex_o = 4'(i);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Scans a multiplexed active-low 7-segment display one digit at a time,
// waits for the segment lines to settle and stabilise, decodes each digit
// and hands a complete frame out over a valid/ready handshake.
// Optional feature: define SEG7_ERR_CNT_EN to add the saturating err_cnt_o
// output counting every digit stored with an error.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DWELL_CYCLES   = 1000,
    parameter int SETTLE_CYCLES  = 16,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEG_W-1:0]      seg_in_i,
    output logic [NUM_DIGITS-1:0] dig_sel_o,
    seg7_scan_reader_if.master    bus
`ifdef SEG7_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt_o
`endif
);

    localparam int SW_RAW = $clog2(SETTLE_CYCLES + 1);
    localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam int DW     = $clog2(DWELL_CYCLES + 1);
    localparam int MW     = $clog2(STABLE_SAMPLES + 1);
    localparam int IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                  state_q,   state_d;
    logic [SW-1:0]           settle_q,  settle_d;
    logic [DW-1:0]           dwell_q,   dwell_d;
    logic [MW-1:0]           match_q,   match_d;
    logic [SEG_W-1:0]        sample_q,  sample_d;
    logic                    timeout_q, timeout_d;
    logic [NUM_DIGITS-1:0]   dig_q,     dig_d;
    logic [IW-1:0]           idx_q,     idx_d;
    logic [4*NUM_DIGITS-1:0] capval_q,  capval_d;
    logic [NUM_DIGITS-1:0]   caperr_q,  caperr_d;
    logic [4*NUM_DIGITS-1:0] value_q,   value_d;
    logic [NUM_DIGITS-1:0]   ferr_q,    ferr_d;
    logic                    valid_q,   valid_d;

    logic [3:0] enc_hex;
    logic       enc_hit;
    logic       store_ok;
    logic       last_digit;

    seg7_pattern_encoder u_encoder (
        .seg_i (sample_q),
        .hex_o (enc_hex),
        .hit_o (enc_hit)
    );

    assign store_ok   = enc_hit & ~timeout_q;
    assign last_digit = (idx_q == IW'(NUM_DIGITS - 1));

    // All registers, cleared asynchronously so a mid-frame reset drops the partial capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SETTLE;
            settle_q  <= '0;
            dwell_q   <= '0;
            match_q   <= '0;
            sample_q  <= '0;
            timeout_q <= 1'b0;
            dig_q     <= NUM_DIGITS'(1);
            idx_q     <= '0;
            capval_q  <= '0;
            caperr_q  <= '0;
            value_q   <= '0;
            ferr_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            dwell_q   <= dwell_d;
            match_q   <= match_d;
            sample_q  <= sample_d;
            timeout_q <= timeout_d;
            dig_q     <= dig_d;
            idx_q     <= idx_d;
            capval_q  <= capval_d;
            caperr_q  <= caperr_d;
            value_q   <= value_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
        end
    end

    // Scan sequencing: settle, wait for a stable pattern or dwell timeout, store, present the frame
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        dwell_d   = dwell_q;
        match_d   = match_q;
        sample_d  = sample_q;
        timeout_d = timeout_q;
        dig_d     = dig_q;
        idx_d     = idx_q;
        capval_d  = capval_q;
        caperr_d  = caperr_q;
        value_d   = value_q;
        ferr_d    = ferr_q;
        valid_d   = valid_q;

        case (state_q)
            SETTLE: begin
                dwell_d   = dwell_q + 1'b1;
                match_d   = '0;
                timeout_d = 1'b0;
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            SAMPLE: begin
                dwell_d  = dwell_q + 1'b1;
                sample_d = seg_in_i;
                if ((match_q != '0) && (seg_in_i == sample_q)) begin
                    match_d = match_q + 1'b1;
                end else begin
                    match_d = MW'(1);
                end
                if (match_d == MW'(STABLE_SAMPLES)) begin
                    state_d = STORE;
                end else if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
                    state_d   = STORE;
                    timeout_d = 1'b1;
                end
            end

            STORE: begin
                capval_d[{idx_q, 2'b00} +: 4] = store_ok ? enc_hex : 4'h0;
                caperr_d[idx_q]               = ~store_ok;
                dwell_d  = '0;
                settle_d = '0;
                match_d  = '0;
                if (last_digit) begin
                    dig_d   = NUM_DIGITS'(1);
                    idx_d   = '0;
                    state_d = PRESENT;
                end else begin
                    dig_d   = dig_q << 1;
                    idx_d   = idx_q + 1'b1;
                    state_d = SETTLE;
                end
            end

            PRESENT: begin
                if (!valid_q) begin
                    value_d = capval_q;
                    ferr_d  = caperr_q;
                    valid_d = 1'b1;
                end else if (bus.ready) begin
                    valid_d = 1'b0;
                    state_d = SETTLE;
                end
            end

            default: begin
                state_d = SETTLE;
            end
        endcase
    end

    assign dig_sel_o     = dig_q;
    assign bus.value     = value_q;
    assign bus.frame_err = ferr_q;
    assign bus.valid     = valid_q;

`ifdef SEG7_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Counts digits stored with an error, sticking at 8'hFF until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if ((state_q == STORE) && !store_ok && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader with a behavioural display model
// driving the segment lines from the selected digit. Uses short settle/dwell
// times; compiles with or without SEG7_ERR_CNT_EN.
module tb_seg7_scan_reader;

    localparam int N       = 4;
    localparam int DWELL   = 64;
    localparam int SETTLE  = 4;
    localparam int STABLE  = 3;
    localparam int LATENCY = N * (SETTLE + STABLE + 1) + 1;

    typedef struct {
        logic [27:0] pats;
        logic [15:0] expValue;
        logic [3:0]  expErr;
    } vector_t;

    logic        clk;
    logic        rst;
    logic [6:0]  segIn;
    logic [3:0]  digSel;
    logic [27:0] curPats;
    logic        toggleEn;
    logic        tglPhase;
    int          checks;
    int          errors;
    int          expErrCnt;
    vector_t     vectors [5];
    logic [6:0]  hexPat [16];

`ifdef SEG7_ERR_CNT_EN
    logic [7:0] errCnt;
`endif

    seg7_scan_reader_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_reader #(
        .NUM_DIGITS     (N),
        .DWELL_CYCLES   (DWELL),
        .SETTLE_CYCLES  (SETTLE),
        .STABLE_SAMPLES (STABLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in_i  (segIn),
        .dig_sel_o (digSel),
        .bus       (bus)
`ifdef SEG7_ERR_CNT_EN
        ,
        .err_cnt_o (errCnt)
`endif
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Toggle phase for the unstable-digit scenario
    initial tglPhase = 1'b0;
    always @(posedge clk) tglPhase <= ~tglPhase;

    // Display model: put the selected digit's pattern on the shared segment lines
    always_comb begin
        segIn = 7'h7F;
        for (int i = 0; i < N; i++) begin
            if (digSel[i]) segIn = curPats[i*7 +: 7];
        end
        if (toggleEn && digSel[1]) segIn = tglPhase ? 7'h24 : 7'h30;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (cycles < 2000) begin
            @(posedge clk);
            cycles++;
            #1;
            if (bus.valid === 1'b1) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_valid: got no valid after %0d cycles, expected valid", cycles);
    endtask

    // Pulse ready for one clock to retire the presented frame
    task automatic acceptFrame();
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
    endtask

    task automatic checkFrame(input string name, input logic [15:0] expValue, input logic [3:0] expErr);
        checkOutput({name, "_value"}, 32'(bus.value), 32'(expValue));
        checkOutput({name, "_err"}, 32'(bus.frame_err), 32'(expErr));
        expErrCnt += $countones(expErr);
`ifdef SEG7_ERR_CNT_EN
        checkOutput({name, "_errcnt"}, 32'(errCnt), 32'(expErrCnt));
`endif
    endtask

    task automatic applyStimulus(input logic [27:0] pats);
        curPats = pats;
        acceptFrame();
    endtask

    initial begin
        int cycles;
        checks    = 0;
        errors    = 0;
        expErrCnt = 0;
        toggleEn  = 1'b0;
        bus.ready = 1'b0;
        rst       = 1'b1;

        hexPat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        vectors[0] = '{{7'h12, 7'h19, 7'h30, 7'h24}, 16'h5432, 4'b0000};
        vectors[1] = '{{7'h12, 7'h7F, 7'h30, 7'h24}, 16'h5032, 4'b0100};
        vectors[2] = '{{7'h06, 7'h0E, 7'h79, 7'h40}, 16'hEF10, 4'b0000};
        vectors[3] = '{{7'h21, 7'h46, 7'h03, 7'h08}, 16'hDCBA, 4'b0000};
        vectors[4] = '{{7'h7F, 7'h10, 7'h00, 7'h7F}, 16'h0980, 4'b1001};

        curPats = vectors[0].pats;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_digsel", 32'(digSel), 32'h1);
        checkOutput("rst_value", 32'(bus.value), 32'h0);
        checkOutput("rst_err", 32'(bus.frame_err), 32'h0);
        checkOutput("rst_valid", 32'(bus.valid), 32'h0);
`ifdef SEG7_ERR_CNT_EN
        checkOutput("rst_errcnt", 32'(errCnt), 32'h0);
`endif

        // First frame after reset: minimum latency with a steady display
        @(negedge clk);
        rst = 1'b0;
        waitValid(cycles);
        checkOutput("latency", 32'(cycles), 32'(LATENCY));
        checkFrame("first", 16'h5432, 4'b0000);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vectors[v].pats);
            waitValid(cycles);
            checkFrame($sformatf("vec%0d", v), vectors[v].expValue, vectors[v].expErr);
        end

        // Digit 1 never stabilises and must time out
        toggleEn = 1'b1;
        applyStimulus(vectors[0].pats);
        waitValid(cycles);
        checkFrame("timeout", 16'h5402, 4'b0010);
        toggleEn = 1'b0;
        curPats  = vectors[0].pats;

        // Back-pressure: frame held stable, scanning parked on digit 0
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (c % 50 == 49) begin
                checkOutput($sformatf("hold%0d_value", c), 32'(bus.value), 32'h5402);
                checkOutput($sformatf("hold%0d_digsel", c), 32'(digSel), 32'h1);
                checkOutput($sformatf("hold%0d_valid", c), 32'(bus.valid), 32'h1);
            end
        end
        acceptFrame();
        checkOutput("ready_drop_valid", 32'(bus.valid), 32'h0);

        // Reset during digit 2 sampling
        cycles = 0;
        while (digSel !== 4'b0100 && cycles < 500) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("reach_digit2", 32'(digSel), 32'h4);
        repeat (SETTLE + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_digsel", 32'(digSel), 32'h1);
        checkOutput("midrst_value", 32'(bus.value), 32'h0);
        checkOutput("midrst_err", 32'(bus.frame_err), 32'h0);
        checkOutput("midrst_valid", 32'(bus.valid), 32'h0);
        expErrCnt = 0;
`ifdef SEG7_ERR_CNT_EN
        checkOutput("midrst_errcnt", 32'(errCnt), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        waitValid(cycles);
        checkFrame("after_rst", 16'h5432, 4'b0000);

        // Sweep every legal pattern through digit 0
        for (int i = 0; i < 16; i++) begin
            applyStimulus({7'h12, 7'h19, 7'h30, hexPat[i]});
            waitValid(cycles);
            checkOutput($sformatf("sweep%0d", i), 32'(bus.value[3:0]), 32'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
